dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the single-port data memory, which has a synchronous 1-cycle read. It shares the memory between the pipeline MEM stage (cpu port) and a debug/loader port (dbg port). Accepted commands are registered onto the memory pins, and read data is routed back to the owning requester. The block bounds dbg starvation, rejects out-of-range and misaligned accesses, and produces the cpu stall term.

---
 rtl/dmem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, 1-cycle-read data memory between the
// pipeline MEM stage (cpu) and a debug/loader port (dbg). The cpu normally
// wins. A burst counter bounds how long a pending dbg request can starve.
// Accepted commands are registered onto the memory pins. A 2-stage owner-tag
// pipeline steers read data and error responses back to the requester.
module dmem_arbiter #(
   parameter int DEPTH         = 64,
   parameter int MAX_CPU_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   // cpu port
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_stall,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   output logic        cpu_err,
   // debug port
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic        dbg_err,
   // memory pins
   output logic        mem_WE,
   output logic        mem_RE,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   input  logic [31:0] mem_RD
);

   localparam int               CNT_W     = $clog2(MAX_CPU_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CPU_BURST);
   localparam logic [29:0]      DEPTH_IDX = 30'(DEPTH);

   // Index 0 is the cpu port, index 1 is the dbg port.
   localparam int NPORT = 2;

   typedef struct packed {
      logic valid;   // an access was accepted in this slot
      logic port;    // 0 = cpu, 1 = dbg
      logic isread;  // read access (only reads return data)
      logic err;     // access was rejected at accept time
   } tag_t;

   // Per-port views of the request inputs
   logic [31:0] addr_a      [NPORT];
   logic        addr_err_a  [NPORT];
   logic        rvalid_a    [NPORT];
   logic        rerr_a      [NPORT];
   logic [31:0] rdata_a     [NPORT];
   logic [31:0] rdata_hold_reg [NPORT];

   // Arbitration state
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             cpu_gnt_w, dbg_gnt_w;

   // Accept-side selected command
   logic        accept;
   logic        sel_dbg;
   logic        sel_we;
   logic        sel_err;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   tag_t        tag_next;

   // Memory-pin registers and owner-tag pipeline
   logic        mem_we_reg, mem_re_reg;
   logic [31:0] mem_a_reg, mem_wd_reg;
   tag_t        tag_reg [2];

   assign addr_a[0] = cpu_addr;
   assign addr_a[1] = dbg_addr;

   // Range and alignment check per port: misaligned or beyond the last word
   // is rejected; high addresses never alias back into the array.
   generate
      for (genvar gi = 0; gi < NPORT; gi++) begin : g_addr_chk
         assign addr_err_a[gi] = (addr_a[gi][1:0] != 2'b00) ||
                                 (addr_a[gi][31:2] >= DEPTH_IDX);
      end
   endgenerate

   // Grant decision: cpu by default, dbg once the cpu has used up its burst
   // allowance while dbg was waiting. No grants while in reset so that a
   // requester never sees an accept that gets thrown away.
   always_comb begin
      cpu_gnt_w = 1'b0;
      dbg_gnt_w = 1'b0;
      if (!rst) begin
         cpu_gnt_w = cpu_req && !(dbg_req && (cnt_reg == CNT_MAX));
         dbg_gnt_w = dbg_req && !cpu_gnt_w;
      end
   end

   assign cpu_gnt   = cpu_gnt_w;
   assign dbg_gnt   = dbg_gnt_w;
   assign cpu_stall = cpu_req & ~cpu_gnt_w;

   // Burst counter next state: count cpu wins against a waiting dbg request,
   // clear once dbg is served or stops asking.
   always_comb begin
      cnt_next = cnt_reg;
      if (cpu_gnt_w && dbg_req) begin
         cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_W'(1);
      end else if (dbg_gnt_w || !dbg_req) begin
         cnt_next = '0;
      end
   end

   // Burst counter register
   always_ff @(posedge clk) begin
      if (rst) cnt_reg <= '0;
      else     cnt_reg <= cnt_next;
   end

   // Select the winning command and build its owner tag
   always_comb begin
      accept    = cpu_gnt_w | dbg_gnt_w;
      sel_dbg   = dbg_gnt_w;
      sel_we    = sel_dbg ? dbg_we        : cpu_we;
      sel_addr  = sel_dbg ? dbg_addr      : cpu_addr;
      sel_wdata = sel_dbg ? dbg_wdata     : cpu_wdata;
      sel_err   = sel_dbg ? addr_err_a[1] : addr_err_a[0];
      tag_next  = '{valid: accept, port: sel_dbg, isread: ~sel_we, err: sel_err};
   end

   // Memory command registers: one-cycle strobes, address/data held when idle
   // or when the accepted access was rejected.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we_reg <= 1'b0;
         mem_re_reg <= 1'b0;
         mem_a_reg  <= '0;
         mem_wd_reg <= '0;
      end else begin
         mem_we_reg <= accept & ~sel_err &  sel_we;
         mem_re_reg <= accept & ~sel_err & ~sel_we;
         if (accept && !sel_err) begin
            mem_a_reg  <= sel_addr;
            mem_wd_reg <= sel_wdata;
         end
      end
   end

   assign mem_WE = mem_we_reg;
   assign mem_RE = mem_re_reg;
   assign mem_A  = mem_a_reg;
   assign mem_WD = mem_wd_reg;

   // Owner-tag shift register: stage 0 lines up with the memory command,
   // stage 1 lines up with mem_RD.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_reg[0] <= '0;
         tag_reg[1] <= '0;
      end else begin
         tag_reg[0] <= tag_next;
         tag_reg[1] <= tag_reg[0];
      end
   end

   // Response steering per port. The port that owns the returning read sees
   // mem_RD directly; the other port keeps showing its last delivered word.
   generate
      for (genvar gi = 0; gi < NPORT; gi++) begin : g_resp
         logic owner;
         assign owner        = tag_reg[1].valid && (tag_reg[1].port == 1'(gi));
         assign rvalid_a[gi] = owner && tag_reg[1].isread && !tag_reg[1].err;
         assign rerr_a[gi]   = owner && tag_reg[1].err;
         assign rdata_a[gi]  = rvalid_a[gi] ? mem_RD : rdata_hold_reg[gi];

         // Remember the last word delivered to this port
         always_ff @(posedge clk) begin
            if (rst)               rdata_hold_reg[gi] <= '0;
            else if (rvalid_a[gi]) rdata_hold_reg[gi] <= mem_RD;
         end
      end
   endgenerate

   assign cpu_rvalid = rvalid_a[0];
   assign cpu_err    = rerr_a[0];
   assign cpu_rdata  = rdata_a[0];
   assign dbg_rvalid = rvalid_a[1];
   assign dbg_err    = rerr_a[1];
   assign dbg_rdata  = rdata_a[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_gnt, cpu_stall, cpu_rvalid, cpu_err;
   logic [31:0] cpu_rdata;
   logic        dbg_req, dbg_we;
   logic [31:0] dbg_addr, dbg_wdata;
   logic        dbg_gnt, dbg_rvalid, dbg_err;
   logic [31:0] dbg_rdata;
   logic        mem_WE, mem_RE;
   logic [31:0] mem_A, mem_WD, mem_RD;

   logic [31:0] mem_model [64];

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DEPTH(64), .MAX_CPU_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
      .mem_WE(mem_WE), .mem_RE(mem_RE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
   );

   // Single-port memory, synchronous 1-cycle read
   always @(posedge clk) begin
      if (mem_WE) mem_model[mem_A[7:2]] <= mem_WD;
      if (mem_RE) mem_RD <= mem_model[mem_A[7:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle();
      cpu_req = 1'b0;
      dbg_req = 1'b0;
   endtask

   initial begin
      logic e1 [10];
      logic e2 [8];
      logic d2 [8];
      e1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      e2 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      d2 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
      mem_model[2]  = 32'hDEAD_BEEF;
      mem_model[63] = 32'hCAFE_F00D;

      rst = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      repeat (3) next_cycle();
      rst = 1'b0;

      // ---- reset state
      $display("txn: reset state");
      sample();
      chk("rst_mem_WE", mem_WE, 0);
      chk("rst_mem_RE", mem_RE, 0);
      chk("rst_mem_A", mem_A, 0);
      chk("rst_mem_WD", mem_WD, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_cpu_err", cpu_err, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dbg_rvalid", dbg_rvalid, 0);
      chk("rst_dbg_err", dbg_err, 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);
      next_cycle();

      // ---- cpu read 0x8
      $display("txn: cpu read 0x00000008");
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
      sample();
      chk("rd8_cpu_gnt", cpu_gnt, 1);
      chk("rd8_dbg_gnt", dbg_gnt, 0);
      chk("rd8_cpu_stall", cpu_stall, 0);
      next_cycle();
      idle();
      sample();
      chk("rd8_mem_RE", mem_RE, 1);
      chk("rd8_mem_WE", mem_WE, 0);
      chk("rd8_mem_A", mem_A, 32'h8);
      chk("rd8_cpu_rvalid_early", cpu_rvalid, 0);
      next_cycle();
      sample();
      chk("rd8_cpu_rvalid", cpu_rvalid, 1);
      chk("rd8_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("rd8_dbg_rvalid", dbg_rvalid, 0);
      chk("rd8_mem_RE_off", mem_RE, 0);
      next_cycle();

      // ---- cpu write 0x10 then read 0x10
      $display("txn: cpu write 0x10 = 0x12345678, then read 0x10");
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1234_5678;
      sample();
      chk("wr10_cpu_gnt", cpu_gnt, 1);
      next_cycle();
      cpu_we = 1'b0; cpu_wdata = 32'h0;
      sample();
      chk("wr10_mem_WE", mem_WE, 1);
      chk("wr10_mem_RE", mem_RE, 0);
      chk("wr10_mem_WD", mem_WD, 32'h1234_5678);
      chk("wr10_mem_A", mem_A, 32'h10);
      chk("rd10_cpu_gnt", cpu_gnt, 1);
      next_cycle();
      idle();
      sample();
      chk("rd10_mem_RE", mem_RE, 1);
      chk("rd10_mem_WE", mem_WE, 0);
      chk("wr10_no_rvalid", cpu_rvalid, 0);
      next_cycle();
      sample();
      chk("rd10_cpu_rvalid", cpu_rvalid, 1);
      chk("rd10_cpu_rdata", cpu_rdata, 32'h1234_5678);
      next_cycle();

      // ---- both ports requesting continuously
      $display("txn: continuous cpu+dbg writes, burst limit 4");
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hA5A5_0020;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h24; dbg_wdata = 32'h5A5A_0024;
      for (int i = 0; i < 10; i++) begin
         sample();
         chk($sformatf("burst%0d_cpu_gnt", i), cpu_gnt, e1[i]);
         chk($sformatf("burst%0d_dbg_gnt", i), dbg_gnt, !e1[i]);
         chk($sformatf("burst%0d_cpu_stall", i), cpu_stall, !e1[i]);
         next_cycle();
      end

      // ---- dbg_req dropping clears the burst count
      $display("txn: dbg request gap restarts the cpu burst");
      for (int i = 0; i < 8; i++) begin
         dbg_req = d2[i];
         sample();
         chk($sformatf("gap%0d_cpu_gnt", i), cpu_gnt, e2[i]);
         chk($sformatf("gap%0d_dbg_gnt", i), dbg_gnt, d2[i] & !e2[i]);
         next_cycle();
      end
      idle();
      next_cycle();

      // ---- misaligned cpu read
      $display("txn: cpu read 0x00000102 (misaligned)");
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h102;
      sample();
      chk("mis_cpu_gnt", cpu_gnt, 1);
      next_cycle();
      idle();
      sample();
      chk("mis_mem_RE", mem_RE, 0);
      chk("mis_mem_WE", mem_WE, 0);
      next_cycle();
      sample();
      chk("mis_cpu_err", cpu_err, 1);
      chk("mis_cpu_rvalid", cpu_rvalid, 0);
      chk("mis_dbg_err", dbg_err, 0);
      next_cycle();

      // ---- out-of-range dbg write
      $display("txn: dbg write 0x00000100 (index 64)");
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h100; dbg_wdata = 32'hFFFF_FFFF;
      sample();
      chk("oor_dbg_gnt", dbg_gnt, 1);
      chk("oor_cpu_gnt", cpu_gnt, 0);
      next_cycle();
      idle();
      sample();
      chk("oor_mem_WE", mem_WE, 0);
      chk("oor_mem_RE", mem_RE, 0);
      next_cycle();
      sample();
      chk("oor_dbg_err", dbg_err, 1);
      chk("oor_dbg_rvalid", dbg_rvalid, 0);
      chk("oor_cpu_err", cpu_err, 0);
      next_cycle();

      // ---- interleaved reads cpu, dbg, cpu
      $display("txn: interleaved reads cpu 0x8, dbg 0xFC, cpu 0x20");
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
      sample();
      chk("il0_cpu_gnt", cpu_gnt, 1);
      next_cycle();
      cpu_req = 1'b0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'hFC;
      sample();
      chk("il1_dbg_gnt", dbg_gnt, 1);
      next_cycle();
      dbg_req = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      sample();
      chk("il2_cpu_gnt", cpu_gnt, 1);
      chk("il2_cpu_rvalid", cpu_rvalid, 1);
      chk("il2_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("il2_dbg_rvalid", dbg_rvalid, 0);
      next_cycle();
      idle();
      sample();
      chk("il3_dbg_rvalid", dbg_rvalid, 1);
      chk("il3_dbg_rdata", dbg_rdata, 32'hCAFE_F00D);
      chk("il3_dbg_err", dbg_err, 0);
      chk("il3_cpu_rvalid", cpu_rvalid, 0);
      chk("il3_cpu_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
      next_cycle();
      sample();
      chk("il4_cpu_rvalid", cpu_rvalid, 1);
      chk("il4_cpu_rdata", cpu_rdata, 32'hA5A5_0020);
      chk("il4_dbg_rvalid", dbg_rvalid, 0);
      chk("il4_dbg_rdata_hold", dbg_rdata, 32'hCAFE_F00D);
      next_cycle();

      // ---- reset right after a cpu read is accepted
      $display("txn: rst in the cycle after a cpu read accept");
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h24;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk($sformatf("pre%0d_cpu_gnt", i), cpu_gnt, 1);
         next_cycle();
      end
      rst = 1'b1;
      cpu_we = 1'b1; cpu_addr = 32'h20;
      next_cycle();
      rst = 1'b0;
      sample();
      chk("post_mem_RE", mem_RE, 0);
      chk("post_mem_WE", mem_WE, 0);
      chk("post_cpu_rvalid", cpu_rvalid, 0);
      chk("post_cpu_err", cpu_err, 0);
      chk("post_cpu_rdata", cpu_rdata, 0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("post%0d_cpu_gnt", i), cpu_gnt, (i < 4) ? 1 : 0);
         chk($sformatf("post%0d_dbg_gnt", i), dbg_gnt, (i < 4) ? 0 : 1);
         next_cycle();
         sample();
         chk($sformatf("post%0d_cpu_rvalid", i), cpu_rvalid, 0);
      end
      idle();
      next_cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
